// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and constants for the comparator scheduler
// Purpose: FSM state encoding, flag register layout and flag reset value
//          shared by cmp_sched and anything that reads the flag register.
// Ports:   none (package).
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } cmp_flags_t;

  localparam cmp_flags_t CMP_FLAGS_RST = '0;

endpackage

// File: rtl/comparator.sv
// rtl/comparator.sv - combinational signed/unsigned magnitude comparator
// Purpose: compares x against y in either signed or unsigned interpretation.
// Ports:
//   x, y             in  WIDTH  operands
//   signed_unsigned  in  1      1 = signed compare, 0 = unsigned
//   negative         out 1      x < y
//   zero             out 1      x == y
//   cout, overflow   out 1      carry/overflow; a pure compare never produces
//                               them, so both are tied low
module comparator #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_unsigned,
  output logic             negative,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  always_comb begin
    if (signed_unsigned) begin
      negative = ($signed(x) < $signed(y));
    end else begin
      negative = (x < y);
    end
    zero     = (x == y);
    cout     = 1'b0;
    overflow = 1'b0;
  end

endmodule

// File: rtl/cmp_sched.sv
// rtl/cmp_sched.sv - round-robin scheduler sharing one comparator among requesters
// Purpose: grants one of NREQ requesters (round robin), runs its compare through
//          the shared comparator, returns the result with a valid/ready handshake
//          and keeps an N/Z/C/V flag register.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         per-requester handshake (ready one-hot or zero)
//   req_x, req_y                packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_signed                  per-requester signed-compare select
//   rsp_valid/rsp_ready         result handshake
//   rsp_id                      index of the requester owning the result
//   rsp_negative, rsp_zero      compare results (x < y, x == y)
//   clr_flags                   synchronous flag clear (wins over an update)
//   flag_n/z/c/v                flag register
//   busy                        high whenever not idle
module cmp_sched
  import cmp_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 2,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  input  logic [NREQ-1:0]       req_signed,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_negative,
  output logic                  rsp_zero,
  input  logic                  clr_flags,
  output logic                  flag_n,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  flag_v,
  output logic                  busy
);

  cmp_state_t       state;
  cmp_flags_t       flags;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic             grant_found;
  logic [WIDTH-1:0] lat_x;
  logic [WIDTH-1:0] lat_y;
  logic             lat_signed;
  logic             cmp_negative;
  logic             cmp_zero;
  logic             cmp_cout;
  logic             cmp_overflow;

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Gated by rst_n so no grant is advertised while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  comparator #(.WIDTH(WIDTH)) u_comparator (
    .x               (lat_x),
    .y               (lat_y),
    .signed_unsigned (lat_signed),
    .negative        (cmp_negative),
    .zero            (cmp_zero),
    .cout            (cmp_cout),
    .overflow        (cmp_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= IDW'(NREQ - 1);
      lat_x        <= '0;
      lat_y        <= '0;
      lat_signed   <= 1'b0;
      rsp_id       <= '0;
      rsp_negative <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|(req_valid & req_ready)) begin
            lat_x      <= req_x[grant_idx*WIDTH +: WIDTH];
            lat_y      <= req_y[grant_idx*WIDTH +: WIDTH];
            lat_signed <= req_signed[grant_idx];
            rsp_id     <= grant_idx;
            last_grant <= grant_idx;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_negative <= cmp_negative;
          rsp_zero     <= cmp_zero;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= CMP_FLAGS_RST;
    end else if (clr_flags) begin
      flags <= CMP_FLAGS_RST;
    end else if (state == EXEC) begin
      flags <= '{n: cmp_negative, z: cmp_zero, c: cmp_cout, v: cmp_overflow};
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign flag_n    = flags.n;
  assign flag_z    = flags.z;
  assign flag_c    = flags.c;
  assign flag_v    = flags.v;

endmodule

// File: tb/tb_cmp_sched.sv
// tb/tb_cmp_sched.sv - self-checking bench for cmp_sched
module tb_cmp_sched;

  localparam int W = 4;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic [N-1:0]   req_signed;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic           rsp_negative;
  logic           rsp_zero;
  logic           clr_flags;
  logic           flag_n, flag_z, flag_c, flag_v;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;
  int m_last;
  logic [3:0] m_flags;

  always #5 clk = ~clk;

  cmp_sched #(.WIDTH(W), .NREQ(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_signed   (req_signed),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_negative (rsp_negative),
    .rsp_zero     (rsp_zero),
    .clr_flags    (clr_flags),
    .flag_n       (flag_n),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .flag_v       (flag_v),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sval(input logic [W-1:0] v, input bit s);
    if (s && v[W-1]) return int'(v) - (1 << W);
    return int'(v);
  endfunction

  function automatic logic [3:0] flags_now();
    return {flag_n, flag_z, flag_c, flag_v};
  endfunction

  // Starts and ends aligned to a falling edge with the DUT idle.
  task automatic run_txn(input logic [N-1:0] v, input logic [N*W-1:0] xs,
                         input logic [N*W-1:0] ys, input logic [N-1:0] s,
                         input int hold, input bit clr);
    int g;
    logic [W-1:0] x, y;
    bit sg, en, ez;
    logic [3:0] ef;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (g < 0 && v[c]) g = c;
    end
    req_valid  = v;
    req_x      = xs;
    req_y      = ys;
    req_signed = s;
    #1;
    chk("grant", 32'(req_ready), 32'(1) << g);
    x  = xs[g*W +: W];
    y  = ys[g*W +: W];
    sg = s[g];
    en = (sval(x, sg) < sval(y, sg));
    ez = (x == y);
    ef = clr ? 4'b0000 : {en, ez, 2'b00};
    m_last = g;
    @(posedge clk);
    #1;
    clr_flags = clr;
    @(negedge clk);
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    clr_flags = 1'b0;
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_negative", 32'(rsp_negative), 32'(en));
    chk("rsp_zero", 32'(rsp_zero), 32'(ez));
    chk("flags", 32'(flags_now()), 32'(ef));
    chk("resp_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_id", 32'(rsp_id), 32'(g));
      chk("hold_rsp_negative", 32'(rsp_negative), 32'(en));
      chk("hold_rsp_zero", 32'(rsp_zero), 32'(ez));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    m_flags = ef;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_x      = '0;
    req_y      = '0;
    req_signed = '0;
    rsp_ready  = 1'b0;
    clr_flags  = 1'b0;
    m_last     = N - 1;
    m_flags    = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_results", 32'({rsp_negative, rsp_zero}), 32'd0);
    chk("rst_flags", 32'(flags_now()), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // Signed 14 vs 3 is -2 < 3; unsigned 14 > 3; then equal operands from requester 1.
    run_txn(2'b01, {4'h0, 4'b1110}, {4'h0, 4'b0011}, 2'b01, 0, 1'b0);
    run_txn(2'b01, {4'h0, 4'b1110}, {4'h0, 4'b0011}, 2'b00, 0, 1'b0);
    run_txn(2'b10, {4'b0101, 4'h0}, {4'b0101, 4'h0}, 2'b00, 0, 1'b0);

    // Both continuously valid: grants must alternate.
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, {4'h7, 4'h9}, {4'h8, 4'h2}, 2'b10, 0, 1'b0);
    end

    // Back-pressure for 5 cycles plus a clear landing on the flag update.
    run_txn(2'b11, {4'h3, 4'h1}, {4'h3, 4'h5}, 2'b11, 5, 1'b1);

    for (int i = 0; i < 12; i++) begin
      run_txn(N'($urandom_range(1, 3)), N*W'($urandom), N*W'($urandom),
              N'($urandom), $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end

    // Reset during EXEC aborts the transaction.
    req_valid  = 2'b10;
    req_x      = {4'h2, 4'h0};
    req_y      = {4'h1, 4'h0};
    req_signed = 2'b00;
    @(posedge clk);
    @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_id", 32'(rsp_id), 32'd0);
    chk("abort_flags", 32'(flags_now()), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n   = 1'b1;
    m_last  = N - 1;
    m_flags = 4'b0000;
    run_txn(2'b11, {4'h4, 4'hc}, {4'h4, 4'h3}, 2'b11, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
